// File: rtl/axi4_pkg.sv
// -----------------------------------------------------------------------------
// axi4_pkg
// Shared AXI4 constants and the request-arbiter FSM state encoding.
//   AXI_RESP_*      : BRESP/RRESP encodings
//   AXI_BURST_INCR  : AxBURST encoding for incrementing bursts
//   arb_state_t     : states of axi4_mem_req_arbiter
// -----------------------------------------------------------------------------
package axi4_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_DONE
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts at the requester after
// last_ptr and wraps, so the most recently served requester has lowest
// priority. The pointer register lives in the parent.
//   req       in  NUM_REQ   request vector
//   last_ptr  in  PTR_W     index of the last granted requester
//   grant     out NUM_REQ   one-hot grant (all zero when no request)
//   grant_idx out PTR_W     index of the granted requester
//   any_req   out 1         at least one request is pending
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any_req
);

    int   idx;
    logic found;

    // NOTE: every variable gets a default at the top of always_comb, otherwise
    // paths that skip an assignment infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = last_ptr;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = PTR_W'(idx);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/axi4_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// axi4_mem_req_arbiter
// Shares one AXI4 slave port among NUM_REQ single-word requesters. Requests
// are granted round-robin in IDLE, executed as one single-beat AXI4
// transaction at a time, and completed with a one-cycle rsp_valid pulse.
//   ACLK, ARESETN            clock, asynchronous active-low reset
//   req_valid/ready/write    per-requester handshake and direction
//   req_addr/wdata/wstrb     flattened per-requester payload
//   rsp_valid/rdata/err      one-hot completion pulse, shared data/error
//   busy                     high whenever the FSM is not in IDLE
//   M_AXI_aw*/w*/b*/ar*/r*   AXI4 master port (len=0, INCR, full width)
// -----------------------------------------------------------------------------
module axi4_mem_req_arbiter
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    // requester side
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              rsp_err,
    output logic                              busy,
    // AW channel
    output logic [ADDR_WIDTH-1:0]             M_AXI_awaddr,
    output logic [7:0]                        M_AXI_awlen,
    output logic [2:0]                        M_AXI_awsize,
    output logic [1:0]                        M_AXI_awburst,
    output logic                              M_AXI_awvalid,
    input  logic                              M_AXI_awready,
    // W channel
    output logic [DATA_WIDTH-1:0]             M_AXI_wdata,
    output logic [DATA_WIDTH/8-1:0]           M_AXI_wstrb,
    output logic                              M_AXI_wlast,
    output logic                              M_AXI_wvalid,
    input  logic                              M_AXI_wready,
    // B channel
    input  logic [1:0]                        M_AXI_bresp,
    input  logic                              M_AXI_bvalid,
    output logic                              M_AXI_bready,
    // AR channel
    output logic [ADDR_WIDTH-1:0]             M_AXI_araddr,
    output logic [7:0]                        M_AXI_arlen,
    output logic [2:0]                        M_AXI_arsize,
    output logic [1:0]                        M_AXI_arburst,
    output logic                              M_AXI_arvalid,
    input  logic                              M_AXI_arready,
    // R channel
    input  logic [DATA_WIDTH-1:0]             M_AXI_rdata,
    input  logic [1:0]                        M_AXI_rresp,
    input  logic                              M_AXI_rlast,
    input  logic                              M_AXI_rvalid,
    output logic                              M_AXI_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));

    arb_state_t           state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   grant_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]    wstrb_q;
    logic                 aw_done;
    logic                 w_done;

    logic [NUM_REQ-1:0]   grant;
    logic [PTR_W-1:0]     grant_idx;
    logic                 any_req;
    logic                 aw_fire;
    logic                 w_fire;

    // Single-beat transfers always end on the first R beat.
    logic unused_rlast;
    assign unused_rlast = M_AXI_rlast;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .last_ptr  (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    assign aw_fire = M_AXI_awvalid && M_AXI_awready;
    assign w_fire  = M_AXI_wvalid  && M_AXI_wready;

    // Payload comes straight from the latched request, so it cannot move
    // while a valid is high.
    assign M_AXI_awaddr  = addr_q;
    assign M_AXI_araddr  = addr_q;
    assign M_AXI_wdata   = wdata_q;
    assign M_AXI_wstrb   = wstrb_q;
    assign M_AXI_awlen   = 8'd0;
    assign M_AXI_arlen   = 8'd0;
    assign M_AXI_awsize  = AXI_SIZE;
    assign M_AXI_arsize  = AXI_SIZE;
    assign M_AXI_awburst = AXI_BURST_INCR;
    assign M_AXI_arburst = AXI_BURST_INCR;
    assign M_AXI_wlast   = 1'b1;

    assign busy = (state != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= ST_IDLE;
            rr_ptr        <= PTR_W'(NUM_REQ - 1);
            grant_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            M_AXI_awvalid <= 1'b0;
            M_AXI_wvalid  <= 1'b0;
            M_AXI_bready  <= 1'b0;
            M_AXI_arvalid <= 1'b0;
            M_AXI_rready  <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        req_ready <= grant;
                        grant_q   <= grant;
                        rr_ptr    <= grant_idx;
                        addr_q    <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q   <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                        wstrb_q   <= req_wstrb[grant_idx*STRB_W +: STRB_W];
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (req_write[grant_idx]) begin
                            M_AXI_awvalid <= 1'b1;
                            M_AXI_wvalid  <= 1'b1;
                            state         <= ST_WR_REQ;
                        end else begin
                            M_AXI_arvalid <= 1'b1;
                            state         <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    // AW and W complete independently, in any order.
                    if (aw_fire) begin
                        M_AXI_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_fire) begin
                        M_AXI_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        M_AXI_bready <= 1'b1;
                        state        <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (M_AXI_bvalid) begin
                        M_AXI_bready <= 1'b0;
                        rsp_err      <= (M_AXI_bresp != AXI_RESP_OKAY);
                        rsp_valid    <= grant_q;
                        state        <= ST_DONE;
                    end
                end
                ST_RD_REQ: begin
                    if (M_AXI_arready) begin
                        M_AXI_arvalid <= 1'b0;
                        M_AXI_rready  <= 1'b1;
                        state         <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (M_AXI_rvalid) begin
                        M_AXI_rready <= 1'b0;
                        rsp_rdata    <= M_AXI_rdata;
                        rsp_err      <= (M_AXI_rresp != AXI_RESP_OKAY);
                        rsp_valid    <= grant_q;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi4_mem_req_arbiter
// Drives axi4_mem_req_arbiter against a 1KB AXI4 memory slave with
// programmable per-channel ready/response delays. Expected grants, response
// data and error flags come from a request-level reference model (word array
// plus a last-grant index).
// -----------------------------------------------------------------------------
module tb_axi4_mem_req_arbiter;
    import axi4_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int SW = DW / 8;

    logic ACLK = 1'b0;
    logic ARESETN;
    always #5 ACLK = ~ACLK;

    logic [NR-1:0]      req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic [NR*SW-1:0]   req_wstrb;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err, busy;

    logic [AW-1:0] M_AXI_awaddr, M_AXI_araddr;
    logic [7:0]    M_AXI_awlen, M_AXI_arlen;
    logic [2:0]    M_AXI_awsize, M_AXI_arsize;
    logic [1:0]    M_AXI_awburst, M_AXI_arburst, M_AXI_bresp, M_AXI_rresp;
    logic          M_AXI_awvalid, M_AXI_awready, M_AXI_wlast, M_AXI_wvalid, M_AXI_wready;
    logic          M_AXI_bvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_arready;
    logic          M_AXI_rlast, M_AXI_rvalid, M_AXI_rready;
    logic [DW-1:0] M_AXI_wdata, M_AXI_rdata;
    logic [SW-1:0] M_AXI_wstrb;

    axi4_mem_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awlen(M_AXI_awlen), .M_AXI_awsize(M_AXI_awsize),
        .M_AXI_awburst(M_AXI_awburst), .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
        .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb), .M_AXI_wlast(M_AXI_wlast),
        .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
        .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid), .M_AXI_bready(M_AXI_bready),
        .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen), .M_AXI_arsize(M_AXI_arsize),
        .M_AXI_arburst(M_AXI_arburst), .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
        .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp), .M_AXI_rlast(M_AXI_rlast),
        .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready)
    );

    // ------------------------------------------------------------------
    // AXI4 memory slave (environment): 256 words, addresses >= 0x400 fail
    // ------------------------------------------------------------------
    logic [DW-1:0] mem [0:255] = '{default: '0};
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int aw_beats = 0, w_beats = 0, ar_beats = 0;
    int cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
    logic          aw_have, w_have, ar_have;
    logic [AW-1:0] cap_awaddr, cap_araddr;
    logic [7:0]    cap_awlen, cap_arlen;
    logic [2:0]    cap_awsize, cap_arsize;
    logic [1:0]    cap_awburst, cap_arburst;
    logic [DW-1:0] cap_wdata;
    logic [SW-1:0] cap_wstrb;
    logic          cap_wlast;

    always @(posedge ACLK) cyc <= cyc + 1;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            M_AXI_awready <= 1'b0; M_AXI_wready <= 1'b0; M_AXI_arready <= 1'b0;
            M_AXI_bvalid  <= 1'b0; M_AXI_bresp  <= 2'b00;
            M_AXI_rvalid  <= 1'b0; M_AXI_rresp  <= 2'b00; M_AXI_rdata <= '0; M_AXI_rlast <= 1'b0;
            aw_have <= 1'b0; w_have <= 1'b0; ar_have <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
        end else begin
            // AW
            if (M_AXI_awvalid && !M_AXI_awready) begin
                if (aw_cnt >= aw_dly) begin M_AXI_awready <= 1'b1; aw_cnt <= 0; end
                else aw_cnt <= aw_cnt + 1;
            end else M_AXI_awready <= 1'b0;
            if (M_AXI_awvalid && M_AXI_awready) begin
                aw_have <= 1'b1; aw_beats <= aw_beats + 1; aw_hs_cyc <= cyc;
                cap_awaddr <= M_AXI_awaddr; cap_awlen <= M_AXI_awlen;
                cap_awsize <= M_AXI_awsize; cap_awburst <= M_AXI_awburst;
            end
            // W
            if (M_AXI_wvalid && !M_AXI_wready) begin
                if (w_cnt >= w_dly) begin M_AXI_wready <= 1'b1; w_cnt <= 0; end
                else w_cnt <= w_cnt + 1;
            end else M_AXI_wready <= 1'b0;
            if (M_AXI_wvalid && M_AXI_wready) begin
                w_have <= 1'b1; w_beats <= w_beats + 1; w_hs_cyc <= cyc;
                cap_wdata <= M_AXI_wdata; cap_wstrb <= M_AXI_wstrb; cap_wlast <= M_AXI_wlast;
            end
            // B
            if (aw_have && w_have && !M_AXI_bvalid) begin
                if (b_cnt >= b_dly) begin
                    b_cnt <= 0;
                    M_AXI_bvalid <= 1'b1;
                    if (cap_awaddr < 32'h400) begin
                        M_AXI_bresp <= AXI_RESP_OKAY;
                        for (int i = 0; i < SW; i++)
                            if (cap_wstrb[i]) mem[cap_awaddr[9:2]][i*8 +: 8] <= cap_wdata[i*8 +: 8];
                    end else M_AXI_bresp <= AXI_RESP_SLVERR;
                end else b_cnt <= b_cnt + 1;
            end else if (M_AXI_bvalid && M_AXI_bready) begin
                M_AXI_bvalid <= 1'b0; aw_have <= 1'b0; w_have <= 1'b0;
            end
            // AR
            if (M_AXI_arvalid && !M_AXI_arready) begin
                if (ar_cnt >= ar_dly) begin M_AXI_arready <= 1'b1; ar_cnt <= 0; end
                else ar_cnt <= ar_cnt + 1;
            end else M_AXI_arready <= 1'b0;
            if (M_AXI_arvalid && M_AXI_arready) begin
                ar_have <= 1'b1; ar_beats <= ar_beats + 1;
                cap_araddr <= M_AXI_araddr; cap_arlen <= M_AXI_arlen;
                cap_arsize <= M_AXI_arsize; cap_arburst <= M_AXI_arburst;
            end
            // R
            if (ar_have && !M_AXI_rvalid) begin
                if (r_cnt >= r_dly) begin
                    r_cnt <= 0;
                    M_AXI_rvalid <= 1'b1; M_AXI_rlast <= 1'b1;
                    if (cap_araddr < 32'h400) begin
                        M_AXI_rdata <= mem[cap_araddr[9:2]]; M_AXI_rresp <= AXI_RESP_OKAY;
                    end else begin
                        M_AXI_rdata <= '0; M_AXI_rresp <= AXI_RESP_DECERR;
                    end
                end else r_cnt <= r_cnt + 1;
            end else if (M_AXI_rvalid && M_AXI_rready) begin
                M_AXI_rvalid <= 1'b0; M_AXI_rlast <= 1'b0; ar_have <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model and checking
    // ------------------------------------------------------------------
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } txn_t;

    logic [31:0] ref_mem [0:255] = '{default: '0};
    int   last_grant = NR - 1;
    txn_t pend [NR][8];
    int   pcnt [NR];
    int   phead[NR];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed no event within bound, expected event", tag);
    endtask

    // Next requester after the last grant that is asking, wrapping around.
    function automatic int exp_grant(input logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++)
            if (v[(last_grant + k) % NR]) return (last_grant + k) % NR;
        return -1;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return (a < 32'h400) ? ref_mem[a[9:2]] : 32'h0;
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a < 32'h400)
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_mem[a[9:2]][i*8 +: 8] = d[i*8 +: 8];
    endfunction

    task automatic add_txn(input int r, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        pend[r][pcnt[r]] = '{wr: wr, addr: a, wdata: d, strb: s};
        pcnt[r]++;
    endtask

    task automatic clear_batch();
        for (int r = 0; r < NR; r++) begin pcnt[r] = 0; phead[r] = 0; end
    endtask

    task automatic drive_head(input int r);
        if (phead[r] < pcnt[r]) begin
            req_valid[r]              = 1'b1;
            req_write[r]              = pend[r][phead[r]].wr;
            req_addr[r*AW +: AW]      = pend[r][phead[r]].addr;
            req_wdata[r*DW +: DW]     = pend[r][phead[r]].wdata;
            req_wstrb[r*SW +: SW]     = pend[r][phead[r]].strb;
        end else begin
            req_valid[r] = 1'b0;
        end
    endtask

    // Runs all queued requests (all requesters held concurrently) and checks
    // each grant, AXI beat and response against the model.
    task automatic run_batch(input string tag);
        int   g, eg, aw0, w0, ar0, n;
        txn_t t;
        logic [NR-1:0] exp_oh;
        @(negedge ACLK);
        for (int r = 0; r < NR; r++) drive_head(r);
        while (|req_valid) begin
            eg = exp_grant(req_valid);
            aw0 = aw_beats; w0 = w_beats; ar0 = ar_beats;
            for (n = 0; n < 200; n++) begin
                @(negedge ACLK);
                if (|req_ready) break;
            end
            if (!(|req_ready)) begin
                timeout_fail($sformatf("%s grant", tag));
                req_valid = '0;
                return;
            end
            exp_oh = '0;
            exp_oh[eg] = 1'b1;
            check($sformatf("%s grant", tag), 64'(req_ready), 64'(exp_oh));
            check($sformatf("%s busy_in_txn", tag), 64'(busy), 64'd1);
            g = eg;
            for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
            last_grant = g;
            t = pend[g][phead[g]];
            phead[g]++;
            drive_head(g);
            for (n = 0; n < 200; n++) begin
                @(negedge ACLK);
                if (|rsp_valid) break;
            end
            if (!(|rsp_valid)) begin
                timeout_fail($sformatf("%s rsp", tag));
                req_valid = '0;
                return;
            end
            exp_oh = '0;
            exp_oh[g] = 1'b1;
            check($sformatf("%s rsp_valid", tag), 64'(rsp_valid), 64'(exp_oh));
            check($sformatf("%s rsp_err a=%0h", tag, t.addr), 64'(rsp_err), 64'(t.addr >= 32'h400));
            if (t.wr) begin
                check($sformatf("%s aw_beats", tag), 64'(aw_beats - aw0), 64'd1);
                check($sformatf("%s w_beats", tag), 64'(w_beats - w0), 64'd1);
                check($sformatf("%s awaddr", tag), 64'(cap_awaddr), 64'(t.addr));
                check($sformatf("%s awlen/size/burst", tag),
                      64'({cap_awlen, cap_awsize, cap_awburst}), 64'({8'd0, 3'd2, 2'b01}));
                check($sformatf("%s wdata/wstrb/wlast", tag),
                      64'({cap_wdata, cap_wstrb, cap_wlast}), 64'({t.wdata, t.strb, 1'b1}));
                ref_write(t.addr, t.wdata, t.strb);
            end else begin
                check($sformatf("%s ar_beats", tag), 64'(ar_beats - ar0), 64'd1);
                check($sformatf("%s araddr", tag), 64'(cap_araddr), 64'(t.addr));
                check($sformatf("%s arlen/size/burst", tag),
                      64'({cap_arlen, cap_arsize, cap_arburst}), 64'({8'd0, 3'd2, 2'b01}));
                check($sformatf("%s rdata a=%0h", tag, t.addr), 64'(rsp_rdata), 64'(ref_read(t.addr)));
            end
            @(negedge ACLK);
            check($sformatf("%s rsp_pulse_end", tag), 64'(rsp_valid), 64'd0);
            check($sformatf("%s idle_after_done", tag), 64'(busy), 64'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, 64'(req_ready), 64'd0);
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, " rsp_err"}, 64'(rsp_err), 64'd0);
        check({tag, " axi valids/readies"},
              64'({M_AXI_awvalid, M_AXI_wvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_rready}), 64'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'h400 + {$urandom_range(0, 15), 2'b00};
        return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    endfunction

    initial begin
        int n;
        ARESETN   = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        clear_batch();
        repeat (3) @(negedge ACLK);
        check_reset_outputs("reset");
        ARESETN = 1'b1;

        // Single write, read-back, partial strobe
        clear_batch(); add_txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF); run_batch("single_write");
        clear_batch(); add_txn(0, 0, 32'h10, 32'h0, 4'h0);        run_batch("readback");
        clear_batch(); add_txn(0, 1, 32'h10, 32'h11223344, 4'b0101);
        add_txn(0, 0, 32'h10, 32'h0, 4'h0);                       run_batch("partial_strobe");

        // Out-of-range read, then an in-range access
        clear_batch(); add_txn(0, 0, 32'h400, 32'h0, 4'h0);
        add_txn(0, 0, 32'h10, 32'h0, 4'h0);                       run_batch("error");

        // Contention: both requesters held for 4 requests each
        clear_batch();
        for (int i = 0; i < 4; i++) begin
            add_txn(0, i[0], 32'h20 + 32'(i*4), 32'hA0A0_0000 + 32'(i), 4'hF);
            add_txn(1, i[0], 32'h40 + 32'(i*4), 32'hB0B0_0000 + 32'(i), 4'hF);
        end
        run_batch("contention");

        // Handshake order: awready 3 cycles after wready, then the reverse
        aw_dly = 3; w_dly = 0;
        clear_batch(); add_txn(1, 1, 32'h30, 32'h5A5A_1234, 4'hF); run_batch("aw_late");
        check("aw_late order", 64'(aw_hs_cyc - w_hs_cyc), 64'd3);
        aw_dly = 0; w_dly = 3;
        clear_batch(); add_txn(1, 1, 32'h34, 32'h0BAD_CAFE, 4'hF);
        add_txn(1, 0, 32'h30, 32'h0, 4'h0); add_txn(1, 0, 32'h34, 32'h0, 4'h0);
        run_batch("w_late");
        w_dly = 0;

        // Randomized batches with random slave timing
        for (int b = 0; b < 30; b++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 2);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 2);
            clear_batch();
            for (int r = 0; r < NR; r++)
                for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                    add_txn(r, bit'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
            run_batch($sformatf("rand%0d", b));
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0;

        // Leave non-reset values in rsp_rdata/rsp_err, then reset inside RD_DATA
        clear_batch(); add_txn(0, 1, 32'h10, 32'hCAFEF00D, 4'hF); add_txn(0, 0, 32'h10, 32'h0, 4'h0);
        add_txn(0, 1, 32'h404, 32'h1, 4'hF); run_batch("pre_reset");
        r_dly = 30;
        @(negedge ACLK);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0 +: AW] = 32'h10;
        for (n = 0; n < 50; n++) begin
            @(negedge ACLK);
            if (|req_ready) req_valid[0] = 1'b0;
            if (M_AXI_rready) break;
        end
        req_valid = '0;
        if (!M_AXI_rready) timeout_fail("reach RD_DATA");
        #2 ARESETN = 1'b0;
        #1 check_reset_outputs("mid_read_reset");
        r_dly = 0;
        last_grant = NR - 1;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;

        // After reset both requesters contend: pointer restarts at NUM_REQ-1
        clear_batch(); add_txn(0, 0, 32'h10, 32'h0, 4'h0); add_txn(1, 0, 32'h30, 32'h0, 4'h0);
        run_batch("post_reset_rr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
